// File: rtl/lc3_pkg.sv
// Shared LC-3 execute definitions:
// opcodes, ALU selects, FSM states.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD = 2'b00;
  localparam logic [1:0] ALUK_AND = 2'b01;
  localparam logic [1:0] ALUK_NOT = 2'b11;

  localparam logic [2:0] NZP_RST = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  // One-hot condition codes {N,Z,P}
  function automatic logic [2:0] nzp_of(
    input logic [15:0] v
  );
    if (v[15])            return 3'b100;
    else if (v == 16'h0)  return 3'b010;
    else                  return 3'b001;
  endfunction

endpackage

// File: rtl/reg_file_8x16.sv
// 8x16 register file: two async read ports,
// a debug read port, one sync write port.
module reg_file_8x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra1,
  output logic [15:0] rd1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd2,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  logic [15:0] regs [8];

  // Clear on reset, otherwise single write port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd1      = regs[ra1];
  assign rd2      = regs[ra2];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute controller for ADD/AND/NOT:
// decode, operand fetch, ALU drive, writeback.
module alu_exec_ctrl
  import lc3_pkg::*;
#(
  parameter logic [2:0] RESET_NZP = NZP_RST
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] IR_in,
  output logic [15:0] IR,
  output logic [1:0]  ALUK,
  output logic        SR2MUX,
  output logic [15:0] SR1,
  output logic [15:0] SR2,
  input  logic [15:0] ALU_OUT,
  output logic        done,
  output logic        illegal,
  output logic [2:0]  NZP,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg_data
);

  state_t      state, nstate;
  logic [3:0]  op;
  logic        legal;
  logic [1:0]  dec_aluk;
  logic        dec_sr2mux;
  logic [15:0] rd1, rd2;
  logic [15:0] result;
  logic        we;

  assign op = IR[15:12];

  reg_file_8x16 u_rf (
    .clk      (Clk),
    .reset    (Reset),
    .we       (we),
    .waddr    (IR[11:9]),
    .wdata    (result),
    .ra1      (IR[8:6]),
    .rd1      (rd1),
    .ra2      (IR[2:0]),
    .rd2      (rd2),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // Opcode decode; NOT never uses the immediate path
  always_comb begin
    legal      = 1'b1;
    dec_aluk   = ALUK_ADD;
    dec_sr2mux = IR[5];
    unique case (1'b1)
      (op == OP_ADD): dec_aluk = ALUK_ADD;
      (op == OP_AND): dec_aluk = ALUK_AND;
      (op == OP_NOT): begin
        dec_aluk   = ALUK_NOT;
        dec_sr2mux = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:   if (instr_valid) nstate = S_DECODE;
      S_DECODE: nstate = legal ? S_EXEC : S_IDLE;
      S_EXEC:   nstate = S_WB;
      S_WB:     nstate = S_IDLE;
    endcase
  end

  // Handshake and pulse outputs; reset masks all
  always_comb begin
    instr_ready = (state == S_IDLE) && !Reset;
    done        = (state == S_WB) && !Reset;
    illegal     = (state == S_DECODE) && !legal
                  && !Reset;
    we          = done;
  end

  // IR latch, operand capture, result and NZP
  always_ff @(posedge Clk) begin
    if (Reset) begin
      IR     <= '0;
      ALUK   <= ALUK_ADD;
      SR2MUX <= 1'b0;
      SR1    <= '0;
      SR2    <= '0;
      result <= '0;
      NZP    <= RESET_NZP;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (instr_valid) IR <= IR_in;
        end
        S_DECODE: begin
          if (legal) begin
            ALUK   <= dec_aluk;
            SR2MUX <= dec_sr2mux;
            SR1    <= rd1;
            SR2    <= rd2;
          end
        end
        S_EXEC: begin
          result <= ALU_OUT;
        end
        S_WB: begin
          NZP    <= nzp_of(result);
          ALUK   <= ALUK_ADD;
          SR2MUX <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: LC-3 ALU stand-in,
// register-file model, directed and random ops.
module tb_alu_exec_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] IR_in = '0;
  logic [15:0] IR;
  logic [1:0]  ALUK;
  logic        SR2MUX;
  logic [15:0] SR1, SR2;
  logic [15:0] ALU_OUT;
  logic        done, illegal;
  logic [2:0]  NZP;
  logic [2:0]  dbg_sel = '0;
  logic [15:0] dbg_data;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mr [8];
  logic [2:0]  mnzp;

  int          o_done, o_ndone, o_ill, o_nill, o_rdy;
  logic        o_sr2m;
  logic [1:0]  o_aluk;
  logic [15:0] o_dbgwb;

  alu_exec_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .IR_in       (IR_in),
    .IR          (IR),
    .ALUK        (ALUK),
    .SR2MUX      (SR2MUX),
    .SR1         (SR1),
    .SR2         (SR2),
    .ALU_OUT     (ALU_OUT),
    .done        (done),
    .illegal     (illegal),
    .NZP         (NZP),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #10 Clk = ~Clk;

  // Combinational LC-3 ALU
  always_comb begin
    logic [15:0] b;
    b = SR2MUX ? {{11{IR[4]}}, IR[4:0]} : SR2;
    case (ALUK)
      2'b00:   ALU_OUT = SR1 + b;
      2'b01:   ALU_OUT = SR1 & b;
      2'b11:   ALU_OUT = ~SR1;
      default: ALU_OUT = 16'hDEAD;
    endcase
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mr[i] = '0;
    mnzp = 3'b010;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op == 4'b0001 || op == 4'b0101
        || op == 4'b1001;
  endfunction

  // Architectural effect of one instruction
  function automatic void model_apply(
    input logic [15:0] ins
  );
    logic [15:0] a, b, res;
    a = mr[ins[8:6]];
    if (ins[5]) b = {{11{ins[4]}}, ins[4:0]};
    else        b = mr[ins[2:0]];
    case (ins[15:12])
      4'b0001: res = a + b;
      4'b0101: res = a & b;
      4'b1001: res = ~a;
      default: return;
    endcase
    mr[ins[11:9]] = res;
    if (res[15])          mnzp = 3'b100;
    else if (res == 16'h0) mnzp = 3'b010;
    else                  mnzp = 3'b001;
  endfunction

  // Issue one instruction, record per-cycle behaviour
  task automatic issue(input logic [15:0] ins);
    int w;
    o_done = -1; o_ill = -1; o_rdy = -1;
    o_ndone = 0; o_nill = 0;
    o_sr2m = 1'bx; o_aluk = 2'bxx;
    o_dbgwb = 'x;
    @(negedge Clk);
    IR_in = ins;
    instr_valid = 1'b1;
    dbg_sel = ins[11:9];
    w = 0;
    while (!instr_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    if (!instr_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept ins=%h ready=%b want 1",
               ins, instr_ready);
      instr_valid = 1'b0;
      return;
    end
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    IR_in = 16'($urandom);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (done) begin
        o_ndone++;
        if (o_done < 0) o_done = c;
      end
      if (illegal) begin
        o_nill++;
        if (o_ill < 0) o_ill = c;
      end
      if (c == 2) begin
        o_sr2m = SR2MUX;
        o_aluk = ALUK;
      end
      if (c == 3) o_dbgwb = dbg_data;
      if (instr_ready) begin
        o_rdy = c;
        break;
      end
    end
    model_apply(ins);
  endtask

  // Build an arbitrary value in R[r] by doubling
  task automatic set_reg(
    input logic [2:0] r,
    input logic [15:0] v
  );
    bit started;
    started = 1'b0;
    issue({4'b0101, r, r, 1'b1, 5'd0});
    for (int i = 15; i >= 0; i--) begin
      if (started) issue({4'b0001, r, r, 3'b000, r});
      if (v[i]) begin
        issue({4'b0001, r, r, 1'b1, 5'd1});
        started = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      n_chk++;
      if (instr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_ready got %b want 0",
                 instr_ready);
      end
    end
    Reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_idle_ready got %b want 1",
               instr_ready);
    end
    n_chk++;
    if ({NZP, ALUK, SR2MUX, done, illegal}
        !== {3'b010, 2'b00, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_outs nzp=%b aluk=%b m=%b d=%b i=%b",
               NZP, ALUK, SR2MUX, done, illegal);
    end
    n_chk++;
    if (IR !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_ir got %h want 0000", IR);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = i[2:0];
      #1;
      n_chk++;
      if (dbg_data !== 16'h0) begin
        n_fail++;
        $display("FAIL rst_reg%0d got %h want 0000",
                 i, dbg_data);
      end
    end
  endtask

  task automatic test_add_reg();
    set_reg(3'd1, 16'd5);
    set_reg(3'd2, 16'd3);
    issue(16'h1042);
    n_chk++;
    if (o_done !== 3 || o_ndone !== 1) begin
      n_fail++;
      $display("FAIL add_done cyc=%0d n=%0d want 3/1",
               o_done, o_ndone);
    end
    n_chk++;
    if (o_rdy !== 4) begin
      n_fail++;
      $display("FAIL add_ready cyc=%0d want 4", o_rdy);
    end
    dbg_sel = 3'd0;
    #1;
    n_chk++;
    if (dbg_data !== 16'd8 || NZP !== 3'b001) begin
      n_fail++;
      $display("FAIL add_r0 got %h/%b want 0008/001",
               dbg_data, NZP);
    end
  endtask

  task automatic test_add_imm();
    set_reg(3'd1, 16'd2);
    issue(16'h167C);
    n_chk++;
    if (o_sr2m !== 1'b1 || o_aluk !== 2'b00) begin
      n_fail++;
      $display("FAIL imm_ctl sr2mux=%b aluk=%b want 1/00",
               o_sr2m, o_aluk);
    end
    dbg_sel = 3'd3;
    #1;
    n_chk++;
    if (dbg_data !== 16'hFFFE || NZP !== 3'b100) begin
      n_fail++;
      $display("FAIL imm_r3 got %h/%b want fffe/100",
               dbg_data, NZP);
    end
  endtask

  task automatic test_and_not();
    set_reg(3'd4, 16'h00F0);
    set_reg(3'd5, 16'h0F0F);
    issue(16'h5D05);
    n_chk++;
    if (o_aluk !== 2'b01 || o_sr2m !== 1'b0) begin
      n_fail++;
      $display("FAIL and_ctl aluk=%b sr2mux=%b want 01/0",
               o_aluk, o_sr2m);
    end
    dbg_sel = 3'd6;
    #1;
    n_chk++;
    if (dbg_data !== 16'h0000 || NZP !== 3'b010) begin
      n_fail++;
      $display("FAIL and_r6 got %h/%b want 0000/010",
               dbg_data, NZP);
    end
    issue(16'h9F3F);
    n_chk++;
    if (o_aluk !== 2'b11 || o_sr2m !== 1'b0) begin
      n_fail++;
      $display("FAIL not_ctl aluk=%b sr2mux=%b want 11/0",
               o_aluk, o_sr2m);
    end
    dbg_sel = 3'd7;
    #1;
    n_chk++;
    if (dbg_data !== 16'hFF0F || NZP !== 3'b100) begin
      n_fail++;
      $display("FAIL not_r7 got %h/%b want ff0f/100",
               dbg_data, NZP);
    end
  endtask

  task automatic test_illegal();
    issue(16'h0000);
    n_chk++;
    if (o_ill !== 1 || o_nill !== 1) begin
      n_fail++;
      $display("FAIL ill_pulse cyc=%0d n=%0d want 1/1",
               o_ill, o_nill);
    end
    n_chk++;
    if (o_ndone !== 0 || o_rdy !== 2) begin
      n_fail++;
      $display("FAIL ill_flow done=%0d rdy=%0d want 0/2",
               o_ndone, o_rdy);
    end
    n_chk++;
    if (NZP !== mnzp) begin
      n_fail++;
      $display("FAIL ill_nzp got %b want %b", NZP, mnzp);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = i[2:0];
      #1;
      n_chk++;
      if (dbg_data !== mr[i]) begin
        n_fail++;
        $display("FAIL ill_reg%0d got %h want %h",
                 i, dbg_data, mr[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d1, acc2, w;
    set_reg(3'd1, 16'h7FFF);
    @(negedge Clk);
    IR_in = 16'h1249;
    instr_valid = 1'b1;
    dbg_sel = 3'd1;
    @(posedge Clk);
    d1 = -1;
    acc2 = -1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge Clk);
      if (done && d1 < 0) d1 = e;
      if (instr_ready) begin
        acc2 = e;
        break;
      end
    end
    model_apply(16'h1249);
    n_chk++;
    if (d1 !== 3 || acc2 !== 4) begin
      n_fail++;
      $display("FAIL b2b_timing done=%0d acc2=%0d want 3/4",
               d1, acc2);
    end
    n_chk++;
    if (dbg_data !== 16'hFFFE || NZP !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_r1 got %h/%b want fffe/100",
               dbg_data, NZP);
    end
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    w = 0;
    do begin
      @(negedge Clk);
      w++;
    end while (!instr_ready && w < 8);
    model_apply(16'h1249);
    n_chk++;
    if (w !== 4 || dbg_data !== mr[1]) begin
      n_fail++;
      $display("FAIL b2b_second cyc=%0d r1=%h want 4/%h",
               w, dbg_data, mr[1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins, old;
    logic [2:0]  dr;
    int          k;
    set_reg(3'd2, 16'($urandom));
    set_reg(3'd5, 16'($urandom));
    for (int n = 0; n < 30; n++) begin
      ins = 16'($urandom);
      k = $urandom_range(0, 4);
      case (k)
        0:       ins[15:12] = 4'b0001;
        1:       ins[15:12] = 4'b0101;
        2, 3:    ins[15:12] = 4'b1001;
        default:
          while (is_legal(ins[15:12]))
            ins[15:12] = 4'($urandom);
      endcase
      if (k == 3) ins[15:12] = 4'b0001;
      dr = ins[11:9];
      old = mr[dr];
      issue(ins);
      if (is_legal(ins[15:12])) begin
        n_chk++;
        if (o_done !== 3 || o_ndone !== 1
            || o_rdy !== 4 || o_nill !== 0) begin
          n_fail++;
          $display("FAIL rnd_flow ins=%h d=%0d n=%0d r=%0d",
                   ins, o_done, o_ndone, o_rdy);
        end
        n_chk++;
        if (o_dbgwb !== old) begin
          n_fail++;
          $display("FAIL rnd_wbdbg ins=%h got %h want %h",
                   ins, o_dbgwb, old);
        end
        dbg_sel = dr;
        #1;
        n_chk++;
        if (dbg_data !== mr[dr] || NZP !== mnzp) begin
          n_fail++;
          $display("FAIL rnd_res ins=%h got %h/%b want %h/%b",
                   ins, dbg_data, NZP, mr[dr], mnzp);
        end
      end else begin
        n_chk++;
        if (o_ill !== 1 || o_ndone !== 0
            || o_rdy !== 2 || NZP !== mnzp) begin
          n_fail++;
          $display("FAIL rnd_ill ins=%h i=%0d d=%0d r=%0d",
                   ins, o_ill, o_ndone, o_rdy);
        end
        dbg_sel = dr;
        #1;
        n_chk++;
        if (dbg_data !== old) begin
          n_fail++;
          $display("FAIL rnd_ill_reg ins=%h got %h want %h",
                   ins, dbg_data, old);
        end
      end
    end
  endtask

  task automatic test_reset_exec();
    int nd;
    set_reg(3'd2, 16'h1234);
    @(negedge Clk);
    IR_in = 16'h1042;
    instr_valid = 1'b1;
    @(posedge Clk);
    #1;
    instr_valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    nd = 0;
    repeat (2) begin
      @(negedge Clk);
      if (done) nd++;
      n_chk++;
      if (instr_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rx_ready_hi got %b want 0",
                 instr_ready);
      end
    end
    Reset = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (instr_ready !== 1'b1 || NZP !== 3'b010
        || IR !== 16'h0 || ALUK !== 2'b00) begin
      n_fail++;
      $display("FAIL rx_state rdy=%b nzp=%b ir=%h aluk=%b",
               instr_ready, NZP, IR, ALUK);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_sel = i[2:0];
      #1;
      n_chk++;
      if (dbg_data !== mr[i]) begin
        n_fail++;
        $display("FAIL rx_reg%0d got %h want %h",
                 i, dbg_data, mr[i]);
      end
    end
    repeat (3) begin
      @(negedge Clk);
      if (done) nd++;
    end
    n_chk++;
    if (nd !== 0 || instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rx_nodone done=%0d rdy=%b want 0/1",
               nd, instr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_add_imm();
    test_and_not();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
